// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Synchronous front-end for the asynchronous sram_memory chip model. Accepts
// one read or write at a time over a valid/ready handshake, then sequences
// the SRAM address, tri-state data bus and active-low strobes through
// SETUP -> ACCESS (WAIT_CYCLES cycles) -> FINISH. Every operation ends with a
// single-cycle rsp_valid pulse. For reads, rsp_rdata carries the word that
// was read.
//
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN
//   When defined, a TURN cycle follows each read. During TURN all strobes are
//   high and the bus is released, so a following write cannot drive the bus
//   into a chip that is still turning off its outputs.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : controller idle and able to accept
//   req_we       : 1 = write, 0 = read
//   req_addr     : word address
//   req_wdata    : write data
//   rsp_valid    : one-cycle completion pulse (reads and writes)
//   rsp_rdata    : read data; keeps its last value across writes
//   sram_addr    : SRAM address pins
//   sram_data    : SRAM bidirectional data pins
//   sram_ce_n    : SRAM chip enable, active low, registered
//   sram_oe_n    : SRAM output enable, active low, registered
//   sram_we_n    : SRAM write enable, active low, registered
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    // A request for zero wait states is stretched to one ACCESS cycle.
    localparam int         WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] ACCESS = 3'd2;
    localparam logic [2:0] FINISH = 3'd3;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam logic [2:0] TURN   = 3'd4;
`endif

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [3:0]            wait_cnt;
    logic                  op_we;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic                  data_oe;
    logic                  accept;
    logic                  next_we;
    logic                  next_busy;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // The strobes are registered from the next state. On the accept edge the
    // operation type has not been latched yet, so it comes from the request.
    assign next_we   = accept ? req_we : op_we;
    assign next_busy = (next_state == SETUP) || (next_state == ACCESS) ||
                       (next_state == FINISH);

    assign sram_data = data_oe ? op_wdata : {DATA_WIDTH{1'bz}};

    // Next-state decode. The ACCESS exit uses the wait counter, which is
    // loaded in SETUP and reaches zero in the last ACCESS cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) next_state = FINISH;
`ifdef SRAM_CTRL_TURNAROUND_EN
            FINISH:  next_state = op_we ? IDLE : TURN;
            TURN:    next_state = IDLE;
`else
            FINISH:  next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (state == SETUP)
                wait_cnt <= CNT_LOAD;
            else if (state == ACCESS && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Request capture. The address register holds its value through IDLE,
    // so the SRAM pins do not move between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we     <= 1'b0;
            op_wdata  <= '0;
            sram_addr <= '0;
        end else if (accept) begin
            op_we     <= req_we;
            op_wdata  <= req_wdata;
            sram_addr <= req_addr;
        end
    end

    // SRAM strobes and bus enable. The write data is driven from SETUP
    // through FINISH, so it brackets the we_n pulse by one cycle on each side.
    // oe_n is only ever low for reads, and the bus is never driven then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            data_oe   <= 1'b0;
        end else begin
            sram_ce_n <= !next_busy;
            sram_oe_n <= !((next_state == ACCESS) && !next_we);
            sram_we_n <= !((next_state == ACCESS) && next_we);
            data_oe   <= next_busy && next_we;
        end
    end

    // Response path. Read data is sampled on the edge that leaves ACCESS,
    // after oe_n has been low for the full wait time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (next_state == FINISH);
            if (state == ACCESS && wait_cnt == 4'd0 && !op_we)
                rsp_rdata <= sram_data;
        end
    end

endmodule
